// File: rtl/riscv_pkg.sv
// Shared types and constants for the program-counter stage.
package riscv_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        TRAP = 2'd3
    } pc_state_t;

    localparam int unsigned INSTR_BYTES = 32'd4;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC target selection (jalr > branch > sequential) and word-alignment check.
module pc_next_sel
    import riscv_pkg::*;
#(
    parameter int Bus_size = 32
) (
    input  logic [Bus_size-1:0] pc_i,
    input  logic                branch_taken_i,
    input  logic [Bus_size-1:0] branch_offset_i,
    input  logic                jalr_en_i,
    input  logic [Bus_size-1:0] jalr_target_i,
    output logic [Bus_size-1:0] next_pc_d_o,
    output logic                misaligned_o
);

    logic [Bus_size-1:0] bit0_clear_s;

    assign bit0_clear_s = ~{{(Bus_size-1){1'b0}}, 1'b1};

    // Target priority; all additions wrap modulo 2^Bus_size.
    always_comb begin
        next_pc_d_o = pc_i + Bus_size'(INSTR_BYTES);
        if (jalr_en_i) begin
            next_pc_d_o = jalr_target_i & bit0_clear_s;
        end else if (branch_taken_i) begin
            next_pc_d_o = pc_i + branch_offset_i;
        end else begin
            next_pc_d_o = pc_i + Bus_size'(INSTR_BYTES);
        end
    end

    assign misaligned_o = is_misaligned(next_pc_d_o[1:0]);

endmodule

// File: rtl/pc_unit.sv
// Program-counter register and fetch-control FSM (BOOT/RUN/HOLD/TRAP).
module pc_unit
    import riscv_pkg::*;
#(
    parameter int                Bus_size     = 32,
    parameter logic [Bus_size-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                imem_ready,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [Bus_size-1:0] branch_offset,
    input  logic                jalr_en,
    input  logic [Bus_size-1:0] jalr_target,
    input  logic                trap_ack,
    output logic [Bus_size-1:0] pc,
    output logic [Bus_size-1:0] pc_plus4,
    output logic                fetch_valid,
    output logic                misalign_trap,
    output logic [Bus_size-1:0] trap_addr
);

    pc_state_t           state_q;
    logic [Bus_size-1:0] pc_q;
    logic                fetch_valid_q;
    logic                misalign_trap_q;
    logic [Bus_size-1:0] trap_addr_q;
    logic [Bus_size-1:0] next_pc_d;
    logic                misaligned_s;
    logic                advance_s;

    pc_next_sel #(.Bus_size(Bus_size)) u_next_sel (
        .pc_i            (pc_q),
        .branch_taken_i  (branch_taken),
        .branch_offset_i (branch_offset),
        .jalr_en_i       (jalr_en),
        .jalr_target_i   (jalr_target),
        .next_pc_d_o     (next_pc_d),
        .misaligned_o    (misaligned_s)
    );

    // Stall has priority over a ready instruction memory.
    assign advance_s = imem_ready & ~stall;

    // FSM, PC register and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= BOOT;
            pc_q            <= RESET_VECTOR;
            fetch_valid_q   <= 1'b0;
            misalign_trap_q <= 1'b0;
            trap_addr_q     <= {Bus_size{1'b0}};
        end else begin
            case (state_q)
                BOOT: begin
                    state_q       <= RUN;
                    fetch_valid_q <= 1'b1;
                end
                RUN, HOLD: begin
                    if (advance_s) begin
                        if (misaligned_s) begin
                            state_q         <= TRAP;
                            fetch_valid_q   <= 1'b0;
                            misalign_trap_q <= 1'b1;
                            trap_addr_q     <= next_pc_d;
                        end else begin
                            state_q       <= RUN;
                            pc_q          <= next_pc_d;
                            fetch_valid_q <= 1'b1;
                        end
                    end else begin
                        state_q       <= HOLD;
                        fetch_valid_q <= 1'b1;
                    end
                end
                TRAP: begin
                    if (trap_ack) begin
                        state_q         <= RUN;
                        pc_q            <= RESET_VECTOR;
                        fetch_valid_q   <= 1'b1;
                        misalign_trap_q <= 1'b0;
                        trap_addr_q     <= {Bus_size{1'b0}};
                    end else begin
                        state_q <= TRAP;
                    end
                end
                default: begin
                    state_q         <= BOOT;
                    pc_q            <= RESET_VECTOR;
                    fetch_valid_q   <= 1'b0;
                    misalign_trap_q <= 1'b0;
                    trap_addr_q     <= {Bus_size{1'b0}};
                end
            endcase
        end
    end

    assign pc            = pc_q;
    assign pc_plus4      = pc_q + Bus_size'(INSTR_BYTES);
    assign fetch_valid   = fetch_valid_q;
    assign misalign_trap = misalign_trap_q;
    assign trap_addr     = trap_addr_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed literal scenarios, then randomized traffic against a behavioural model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ready;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jalr_en;
    logic [31:0] jalr_target;
    logic        trap_ack;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        misalign_trap;
    logic [31:0] trap_addr;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state
    logic [31:0] m_pc     = 32'h0;
    logic        m_fv     = 1'b0;
    logic        m_trap   = 1'b0;
    logic [31:0] m_taddr  = 32'h0;
    bit          m_boot   = 1'b1;
    bit          model_on = 1'b0;

    pc_unit #(.Bus_size(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_ready    (imem_ready),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jalr_en       (jalr_en),
        .jalr_target   (jalr_target),
        .trap_ack      (trap_ack),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid),
        .misalign_trap (misalign_trap),
        .trap_addr     (trap_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference behaviour: what the next cycle's outputs must be given this cycle's inputs.
    always @(posedge clk) begin
        logic [31:0] tgt;
        if (reset) begin
            m_pc = 32'h0; m_fv = 1'b0; m_trap = 1'b0; m_taddr = 32'h0; m_boot = 1'b1;
            model_on = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0; m_fv = 1'b1;
        end else if (m_trap) begin
            if (trap_ack) begin
                m_trap = 1'b0; m_pc = 32'h0; m_fv = 1'b1; m_taddr = 32'h0;
            end
        end else if (imem_ready && !stall) begin
            if (jalr_en)           tgt = jalr_target - (jalr_target % 2);
            else if (branch_taken) tgt = m_pc + branch_offset;
            else                   tgt = m_pc + 32'd4;
            if (tgt % 4 != 0) begin
                m_trap = 1'b1; m_fv = 1'b0; m_taddr = tgt;
            end else begin
                m_pc = tgt;
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (model_on) begin
            check("model_pc", pc, m_pc);
            check("model_pc_plus4", pc_plus4, m_pc + 32'd4);
            check("model_fetch_valid", {31'b0, fetch_valid}, {31'b0, m_fv});
            check("model_misalign_trap", {31'b0, misalign_trap}, {31'b0, m_trap});
            if (m_trap) check("model_trap_addr", trap_addr, m_taddr);
        end
    end

    task automatic apply(input logic rst, input logic rdy, input logic stl,
                         input logic br, input logic [31:0] off,
                         input logic jen, input logic [31:0] jt, input logic ack);
        reset = rst; imem_ready = rdy; stall = stl; branch_taken = br;
        branch_offset = off; jalr_en = jen; jalr_target = jt; trap_ack = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [31:0] addr);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, addr, 1'b0);
        check("go_to", pc, addr);
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        branch_offset = 32'h0; jalr_en = 1'b0; jalr_target = 32'h0; trap_ack = 1'b0;

        // 1: reset, boot, sequential fetch
        apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("rst_pc", pc, 32'h0);
        check("rst_fv", {31'b0, fetch_valid}, 32'd0);
        check("rst_trap", {31'b0, misalign_trap}, 32'd0);
        check("rst_taddr", trap_addr, 32'h0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("boot_exit_pc", pc, 32'h0);
        check("boot_exit_fv", {31'b0, fetch_valid}, 32'd1);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("seq_pc4", pc, 32'h4);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("seq_pc8", pc, 32'h8);

        // 2: negative branch
        go_to(32'h100);
        apply(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 32'h0, 1'b0);
        check("branch_back_pc", pc, 32'hF0);
        check("branch_back_plus4", pc_plus4, 32'hF4);

        // 3: jalr beats branch, bit 0 cleared
        go_to(32'h20);
        apply(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h81, 1'b0);
        check("jalr_priority", pc, 32'h80);

        // 4: stall holds even with imem_ready; redirect ignored while holding
        go_to(32'h40);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        check("stall1_pc", pc, 32'h40);
        check("stall1_fv", {31'b0, fetch_valid}, 32'd1);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("stall2_pc", pc, 32'h40);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("stall_release_pc", pc, 32'h44);

        // 5: misaligned branch target traps; trap_ack returns to reset vector
        go_to(32'h10);
        apply(1'b0, 1'b1, 1'b0, 1'b1, 32'h6, 1'b0, 32'h0, 1'b0);
        check("trap_flag", {31'b0, misalign_trap}, 32'd1);
        check("trap_addr", trap_addr, 32'h16);
        check("trap_pc", pc, 32'h10);
        check("trap_fv", {31'b0, fetch_valid}, 32'd0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("trap_waits_pc", pc, 32'h10);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("trap_ack_pc", pc, 32'h0);
        check("trap_ack_clear", {31'b0, misalign_trap}, 32'd0);
        check("trap_ack_fv", {31'b0, fetch_valid}, 32'd1);

        // 6: wrap to zero, then reset while trapped
        go_to(32'hFFFF_FFFC);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("wrap_pc", pc, 32'h0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2A, 1'b0);
        check("jalr_misalign_taddr", trap_addr, 32'h2A);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("rst_in_trap_flag", {31'b0, misalign_trap}, 32'd0);
        check("rst_in_trap_fv", {31'b0, fetch_valid}, 32'd0);
        check("rst_in_trap_taddr", trap_addr, 32'h0);

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] off;
            logic [31:0] jt;
            off = ($urandom_range(0, 63) - 32'd32) * 32'd4;
            if ($urandom_range(0, 9) == 0) off = off + 32'($urandom_range(1, 3));
            jt = $urandom;
            if ($urandom_range(0, 3) != 0) jt = jt & 32'hFFFF_FFFD;
            apply(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 3) == 0), off,
                  ($urandom_range(0, 7) == 0), jt,
                  ($urandom_range(0, 2) == 0));
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
